alu_serial_seq: RTL and testbench

//  Bit-serial ALU sequencer: accepts two WIDTH-bit operands plus a mode, feeds them
//  LSB-first through a 1-bit ALU slice (one bit per clock) and collects the slice's
//  out/next bits into a WIDTH-bit result and carry-out. It is the consumer side of the
//  1-bit ALU slice: it drives M/a/b/c and registers out/next each cycle.

---
 rtl/alu_serial_seq.sv | 135 +++++++++++++
 tb/tb_alu_serial_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: streams two latched operands LSB-first through a 1-bit ALU slice.
// Optional feature: define ALU_SERIAL_ZERO_FLAG_EN to add the serially computed zero output.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, result_reg;
    logic [2:0]       mode_reg;
    logic             carry_reg, cout_reg, done_reg;
    logic [CW-1:0]    cnt_reg;
    logic             slice_out, slice_next;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic             zacc_reg, zero_reg;
`endif

    // 1-bit ALU slice fed from the low bits of the shift registers
    always_comb begin
        slice_out  = 1'b0;
        slice_next = 1'b0;
        case (mode_reg)
            3'b000: begin
                slice_out  = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
                slice_next = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg) |
                             (b_sh_reg[0] & carry_reg);
            end
            3'b001:  slice_out = a_sh_reg[0] & b_sh_reg[0];
            3'b010:  slice_out = a_sh_reg[0] | b_sh_reg[0];
            3'b011:  slice_out = a_sh_reg[0] ^ b_sh_reg[0];
            3'b100:  slice_out = ~(a_sh_reg[0] ^ b_sh_reg[0]);
            default: slice_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            result_reg <= '0;
            mode_reg   <= 3'b000;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cnt_reg    <= '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zacc_reg   <= 1'b0;
            zero_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    a_sh_reg   <= a;
                    b_sh_reg   <= b;
                    mode_reg   <= mode;
                    carry_reg  <= (mode == 3'b000) ? cin : 1'b0;
                    cnt_reg    <= '0;
                    result_reg <= '0;
                    cout_reg   <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zacc_reg   <= 1'b1;
                    zero_reg   <= 1'b0;
`endif
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    result_reg <= {slice_out, result_reg[WIDTH-1:1]};
                    carry_reg  <= (mode_reg == 3'b000) ? slice_next : 1'b0;
                    cnt_reg    <= cnt_reg + 1'b1;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zacc_reg   <= zacc_reg & ~slice_out;
`endif
                end
                // done is registered, so it pulses in the cycle after DONE with the result stable
                DONE: begin
                    done_reg <= 1'b1;
                    cout_reg <= carry_reg;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zero_reg <= zacc_reg;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg == SHIFT);
    assign done   = done_reg;
    assign result = result_reg;
    assign cout   = cout_reg;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign zero   = zero_reg;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: expected results queued at stimulus, checked on done.
module tb_alu_serial_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy, done, cout;
    logic [WIDTH-1:0] result;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic             zero;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [WIDTH:0] exp_q[$];

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [2:0] m, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y, input logic c);
        case (m)
            3'b000:  return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
            3'b001:  return {1'b0, x & y};
            3'b010:  return {1'b0, x | y};
            3'b011:  return {1'b0, x ^ y};
            3'b100:  return {1'b0, ~(x ^ y)};
            default: return '0;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation
    always @(posedge clk) begin
        logic [WIDTH:0] e;
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e[WIDTH-1:0]));
                check("cout", 32'(cout), 32'(e[WIDTH]));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                check("zero", 32'(zero), 32'(e[WIDTH-1:0] == '0));
`endif
                $display("op done: result=0x%0h cout=%0b", result, cout);
            end
        end
    end

    // Runs one op and measures start-to-done latency; optionally pokes start mid-flight
    task automatic run_op(input logic [2:0] m, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic c, input int poke);
        int cnt;
        exp_q.push_back(model(m, x, y, c));
        @(negedge clk);
        mode = m; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x; b = ~y; cin = ~c;
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (poke > 0 && cnt == poke) begin
                start = 1'b1; a = 8'h11; b = 8'h22; mode = 3'b010;
            end else if (poke > 0 && cnt == poke + 1) begin
                start = 1'b0;
            end
            if (done) break;
        end
        check("latency", 32'(cnt), 32'(WIDTH + 1));
        @(negedge clk);
    endtask

    initial begin
        int cnt, t1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        check("rst_zero", 32'(zero), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // arithmetic and logic modes
        run_op(3'b000, 8'h5A, 8'h33, 1'b0, 0);
        run_op(3'b000, 8'hFF, 8'h01, 1'b1, 0);
        run_op(3'b001, 8'hF0, 8'h3C, 1'b1, 0);
        run_op(3'b010, 8'hF0, 8'h3C, 1'b0, 0);
        run_op(3'b011, 8'hF0, 8'h3C, 1'b0, 0);
        run_op(3'b100, 8'hA5, 8'h0F, 1'b0, 0);
        run_op(3'b101, 8'hA5, 8'h0F, 1'b1, 0);
        run_op(3'b111, 8'hFF, 8'hFF, 1'b1, 0);

        // start during busy must be ignored
        run_op(3'b000, 8'h12, 8'h34, 1'b1, 3);
        repeat (3) @(negedge clk);

        // reset mid-operation: outputs return to reset values, no done
        mode = 3'b000; a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        run_op(3'b000, 8'h80, 8'h80, 1'b0, 0);

        // start held high: second op accepted on first IDLE cycle after done
        exp_q.push_back(model(3'b000, 8'hC8, 8'h64, 1'b1));
        exp_q.push_back(model(3'b011, 8'h0F, 8'hF3, 1'b0));
        mode = 3'b000; a = 8'hC8; b = 8'h64; cin = 1'b1; start = 1'b1;
        cnt = 0;
        while (!busy && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("held_busy", 32'(busy), 32'd1);
        mode = 3'b011; a = 8'h0F; b = 8'hF3; cin = 1'b0;
        cnt = 0; t1 = 0;
        while (cnt < 60) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done && t1 == 0) t1 = cnt;
            else if (done) break;
        end
        start = 1'b0;
        check("held_gap", 32'(cnt - t1), 32'(WIDTH + 2));
        repeat (3) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
